// File: rtl/laser_sweep_ctrl_pkg.sv
// Shared types and constants for the LASER two-circle sweep scheduler.
package laser_pkg;

    // Controller states, in the order a normal search visits them.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        INIT   = 3'd1,
        SWEEP1 = 3'd2,
        SWEEP2 = 3'd3,
        CHECK  = 3'd4,
        OUTPUT = 3'd5
    } state_t;

    localparam int COORD_W = 4;
    localparam int N_PTS   = 40;

    // Starting centers: spread the two circles across the grid diagonal.
    localparam logic [COORD_W-1:0] INIT_C1_X = 4'd4;
    localparam logic [COORD_W-1:0] INIT_C1_Y = 4'd4;
    localparam logic [COORD_W-1:0] INIT_C2_X = 4'd11;
    localparam logic [COORD_W-1:0] INIT_C2_Y = 4'd11;

endpackage

// File: rtl/laser_sweep_ctrl_if.sv
// Candidate-evaluation handshake between the sweep controller (master)
// and the external coverage evaluator (slave).
interface laser_sweep_ctrl_if #(
    parameter int CNT_W = 6
);
    logic             eval_req;
    logic             eval_ack;
    logic [CNT_W-1:0] eval_cnt;
    logic [3:0]       cand_x;
    logic [3:0]       cand_y;
    logic [3:0]       fix_x;
    logic [3:0]       fix_y;

    modport master (
        output eval_req, cand_x, cand_y, fix_x, fix_y,
        input  eval_ack, eval_cnt
    );

    modport slave (
        input  eval_req, cand_x, cand_y, fix_x, fix_y,
        output eval_ack, eval_cnt
    );
endinterface

// File: rtl/laser_raster_cnt.sv
// Raster candidate index: y in the upper nibble, x in the lower, so a plain
// increment walks x inner / y outer and wraps 255 -> 0 at the end of a sweep.
module laser_raster_cnt (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_clr,
    input  logic       i_adv,
    output logic [3:0] o_cand_x,
    output logic [3:0] o_cand_y,
    output logic       o_last
);
    logic [7:0] r_idx;

    // Index register: cleared outside sweeps, advanced on each accepted candidate.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_idx <= 8'd0;
        end else if (i_adv) begin
            r_idx <= r_idx + 8'd1;
        end
    end

    assign o_cand_x = r_idx[3:0];
    assign o_cand_y = r_idx[7:4];
    assign o_last   = (r_idx == 8'hFF);
endmodule

// File: rtl/laser_sweep_ctrl.sv
// Sweep scheduler for the LASER two-circle coverage search.
// Optional feature macro: LASER_EARLY_EXIT_EN (full coverage ends the search
// immediately with the current candidate).
//
//   state  | meaning
//   IDLE   | waiting for start
//   INIT   | load starting centers, clear pass history
//   SWEEP1 | raster C1 candidates against fixed C2
//   SWEEP2 | raster C2 candidates against fixed C1
//   CHECK  | decide between another pass pair and finishing
//   OUTPUT | one-cycle DONE strobe
module laser_sweep_ctrl
    import laser_pkg::*;
#(
    parameter int MAX_ITER = 4,
    parameter int CNT_W    = 6
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               start,
    output logic               busy,
    laser_sweep_ctrl_if.master eval_bus,
    output logic [COORD_W-1:0] C1X,
    output logic [COORD_W-1:0] C1Y,
    output logic [COORD_W-1:0] C2X,
    output logic [COORD_W-1:0] C2Y,
    output logic               DONE
);
    state_t             r_state;
    logic               r_busy;
    logic               r_eval_req;
    logic               r_done;
    logic [COORD_W-1:0] r_fix_x, r_fix_y;
    logic [COORD_W-1:0] r_c1x, r_c1y, r_c2x, r_c2y;
    logic [COORD_W-1:0] r_best_x, r_best_y;
    logic [CNT_W-1:0]   r_best_cnt;
    logic [CNT_W-1:0]   r_prev_total;
    logic [2:0]         r_iter;

    logic               w_hs;
    logic               w_better;
    logic               w_full;
    logic               w_last;
    logic               w_clr;
    logic [COORD_W-1:0] w_sel_x, w_sel_y;
    logic [COORD_W-1:0] w_cand_x, w_cand_y;

    assign w_hs     = r_eval_req && eval_bus.eval_ack;
    assign w_better = w_hs && (eval_bus.eval_cnt > r_best_cnt);
    assign w_full   = w_hs && (eval_bus.eval_cnt == CNT_W'(N_PTS));
    assign w_clr    = (r_state != SWEEP1) && (r_state != SWEEP2);
    // Winner of the sweep including the sample being accepted this cycle.
    assign w_sel_x  = w_better ? w_cand_x : r_best_x;
    assign w_sel_y  = w_better ? w_cand_y : r_best_y;

    laser_raster_cnt u_raster (
        .i_clk    (CLK),
        .i_rst    (RST),
        .i_clr    (w_clr),
        .i_adv    (w_hs),
        .o_cand_x (w_cand_x),
        .o_cand_y (w_cand_y),
        .o_last   (w_last)
    );

    assign eval_bus.cand_x   = w_cand_x;
    assign eval_bus.cand_y   = w_cand_y;
    assign eval_bus.eval_req = r_eval_req;
    assign eval_bus.fix_x    = r_fix_x;
    assign eval_bus.fix_y    = r_fix_y;
    assign busy = r_busy;
    assign DONE = r_done;
    assign C1X  = r_c1x;
    assign C1Y  = r_c1y;
    assign C2X  = r_c2x;
    assign C2Y  = r_c2y;

    // Search FSM with all outputs registered.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= IDLE;
            r_busy       <= 1'b0;
            r_eval_req   <= 1'b0;
            r_done       <= 1'b0;
            r_fix_x      <= '0;
            r_fix_y      <= '0;
            r_c1x        <= '0;
            r_c1y        <= '0;
            r_c2x        <= '0;
            r_c2y        <= '0;
            r_best_x     <= '0;
            r_best_y     <= '0;
            r_best_cnt   <= '0;
            r_prev_total <= '0;
            r_iter       <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_busy  <= 1'b1;
                        r_state <= INIT;
                    end
                end
                INIT: begin
                    r_c1x        <= INIT_C1_X;
                    r_c1y        <= INIT_C1_Y;
                    r_c2x        <= INIT_C2_X;
                    r_c2y        <= INIT_C2_Y;
                    r_prev_total <= '0;
                    r_iter       <= '0;
                    r_best_cnt   <= '0;
                    r_best_x     <= '0;
                    r_best_y     <= '0;
                    r_fix_x      <= INIT_C2_X;
                    r_fix_y      <= INIT_C2_Y;
                    r_eval_req   <= 1'b1;
                    r_state      <= SWEEP1;
                end
                SWEEP1: begin
                    if (w_better) begin
                        r_best_cnt <= eval_bus.eval_cnt;
                        r_best_x   <= w_cand_x;
                        r_best_y   <= w_cand_y;
                    end
                    if (w_hs && w_last) begin
                        r_c1x      <= w_sel_x;
                        r_c1y      <= w_sel_y;
                        r_fix_x    <= w_sel_x;
                        r_fix_y    <= w_sel_y;
                        r_best_cnt <= '0;
                        r_best_x   <= '0;
                        r_best_y   <= '0;
                        r_state    <= SWEEP2;
                    end
`ifdef LASER_EARLY_EXIT_EN
                    if (w_full) begin
                        r_c1x      <= w_cand_x;
                        r_c1y      <= w_cand_y;
                        r_eval_req <= 1'b0;
                        r_done     <= 1'b1;
                        r_state    <= OUTPUT;
                    end
`endif
                end
                SWEEP2: begin
                    if (w_better) begin
                        r_best_cnt <= eval_bus.eval_cnt;
                        r_best_x   <= w_cand_x;
                        r_best_y   <= w_cand_y;
                    end
                    // best_cnt survives the end of SWEEP2 so CHECK can judge the pair.
                    if (w_hs && w_last) begin
                        r_c2x      <= w_sel_x;
                        r_c2y      <= w_sel_y;
                        r_eval_req <= 1'b0;
                        r_state    <= CHECK;
                    end
`ifdef LASER_EARLY_EXIT_EN
                    if (w_full) begin
                        r_c2x      <= w_cand_x;
                        r_c2y      <= w_cand_y;
                        r_eval_req <= 1'b0;
                        r_done     <= 1'b1;
                        r_state    <= OUTPUT;
                    end
`endif
                end
                CHECK: begin
                    r_iter <= r_iter + 3'd1;
                    if ((r_best_cnt > r_prev_total) && (int'(r_iter) + 1 < MAX_ITER)) begin
                        r_prev_total <= r_best_cnt;
                        r_best_cnt   <= '0;
                        r_best_x     <= '0;
                        r_best_y     <= '0;
                        r_fix_x      <= r_c2x;
                        r_fix_y      <= r_c2y;
                        r_eval_req   <= 1'b1;
                        r_state      <= SWEEP1;
                    end else begin
                        r_done  <= 1'b1;
                        r_state <= OUTPUT;
                    end
                end
                OUTPUT: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/laser_sweep_ctrl.md
# laser_sweep_ctrl

Sweep scheduler for the LASER two-circle coverage datapath. After the 40 input points are loaded, it steps a candidate circle center over all 256 grid positions, requesting a coverage count for each from the external coverage evaluator while the other circle is held fixed. It alternates between optimizing C1 and C2 until the total coverage stops improving, then presents C1X/C1Y/C2X/C2Y and pulses DONE.

## Interface
- MAX_ITER, default 4: maximum number of C1+C2 pass pairs.
- CNT_W, default 6: width of coverage counts (0..40).
- CLK  in  1  sole clock, rising edge.
- RST  in  1  synchronous reset, active-high.
- start  in  1  single-cycle pulse: point memory is loaded, begin search.
- busy  out  1  high from INIT through OUTPUT inclusive.
- eval_req  out  1  candidate evaluation request.
- eval_ack  in  1  evaluator accepts the request; eval_cnt is valid in the same cycle.
- eval_cnt  in  CNT_W  points covered by the union of the candidate circle and the fixed circle.
- cand_x, cand_y  out  4  candidate center.
- fix_x, fix_y  out  4  fixed (other) circle center.
- C1X, C1Y, C2X, C2Y  out  4 each  result centers (registered).
- DONE  out  1  one-cycle result strobe.
- Clock is CLK. Reset is RST: synchronous, active-high.

## Operation
- States: IDLE, INIT, SWEEP1, SWEEP2, CHECK, OUTPUT.
- IDLE
  - start goes to INIT.
  - start is ignored in all other states.
- INIT (1 cycle)
  - C1 := (4,4), C2 := (11,11).
  - prev_total := 0, iter := 0.
- SWEEP1
  - fixed center = C2.
  - Candidate follows raster order: y outer, x inner, from (0,0) to (15,15).
  - best_cnt is cleared at sweep entry.
  - On each handshake (eval_req && eval_ack): if eval_cnt > best_cnt (strict), capture eval_cnt and the candidate position. Ties keep the earlier raster position.
  - On the handshake at (15,15): C1 := best position (including that final sample), then go to SWEEP2.
- SWEEP2
  - Same as SWEEP1 with fixed = C1.
  - Ends by loading C2, then goes to CHECK.
- CHECK (1 cycle)
  - iter := iter+1.
  - If best_cnt > prev_total and iter+1 < MAX_ITER: prev_total := best_cnt, go to SWEEP1.
  - Otherwise go to OUTPUT.
- OUTPUT (1 cycle)
  - DONE = 1, then go to IDLE.
  - C outputs hold their values until the next INIT.
- Arithmetic
  - Counts are unsigned CNT_W-bit.
  - Raster index is 8 bits and wraps 255→0 at sweep end.
  - iter is 3 bits.

## Timing
- Reset values: C1X=C1Y=C2X=C2Y=0, DONE=0, busy=0, eval_req=0, cand_x/cand_y/fix_x/fix_y=0; state IDLE.
- Reset mid-operation: the next edge gives IDLE with all outputs at reset values. Any in-flight request is dropped.
- eval_req is high in every SWEEP cycle and low elsewhere.
- cand_x/cand_y/fix_x/fix_y are stable while eval_req=1 and eval_ack=0.
- A combinational ack in the same cycle is allowed. With eval_ack tied high, throughput is one candidate per cycle and each sweep takes 256 cycles.
- eval_ack is ignored while eval_req=0.
- Latency with ack tied high, where t0 is the cycle start is sampled:
  - INIT occupies t0+1.
  - Each pass pair takes 513 cycles.
  - For P pass pairs, DONE is high in cycle t0+2+513·P.

## Configuration
- LASER_EARLY_EXIT_EN defined:
  - A handshake with eval_cnt == 40 loads the center currently being optimized with that candidate.
  - The controller then goes directly to OUTPUT on the next edge.
- LASER_EARLY_EXIT_EN undefined: sweeps always complete. Behaviour is exactly as described in Operation.

## Structure
- laser_pkg holds:
  - state enum;
  - COORD_W=4, N_PTS=40;
  - INIT_C1=(4,4), INIT_C2=(11,11).
- Sub-module laser_raster_cnt: 8-bit candidate index with clear, advance-on-handshake and last flag (index==255). It drives cand_x/cand_y.

## Test plan
- Reset: hold RST for 2 cycles mid-SWEEP1 → next cycle state IDLE, eval_req=0, busy=0, all C outputs 0, DONE=0.
- Convergence:
  - Stimulus: ack tied high; model returns 10 at cand (3,5) in SWEEP1, 10 at (12,9) in SWEEP2, else 0.
  - Response: P=2, DONE high at t0+1028 with C1=(3,5), C2=(12,9).
- Stall: drop eval_ack for 5 cycles at cand (6,0) → cand/fix/eval_req unchanged across the stall; the sweep ends 5 cycles later.
- Tie: model returns 7 at both (2,2) and (9,9) in SWEEP1 → C1=(2,2).
- MAX_ITER=2 with a model whose count increases every pair → exactly 2 pairs, DONE at t0+1028.
- Early exit: eval_cnt=40 at (7,7) in SWEEP1.
  - With LASER_EARLY_EXIT_EN: DONE one cycle later, C1=(7,7), C2=(11,11).
  - Without it: the sweep continues to (15,15).
